// File: rtl/dot_product_seq_ctrl.sv
// Serial dot-product controller: one shared multiplier and accumulator, fed N pairs over valid/ready.
// Optional overflow reporting is compiled in with the DOT_SEQ_OVF_EN macro.
module dot_product_seq_ctrl #(
  parameter int N = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a_elem,
  input  logic [N-1:0]   b_elem,
  output logic [IW-1:0]  elem_idx,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] result
`ifdef DOT_SEQ_OVF_EN
  ,
  output logic           ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t          state, state_next;
  logic [2*N-1:0]  acc;
  logic [2*N-1:0]  prod;
  logic [2*N-1:0]  sum;
  logic [IW-1:0]   idx;
  logic            transfer;
  logic            start_accept;
  logic            last_pair;

  assign prod         = {{N{1'b0}}, a_elem} * {{N{1'b0}}, b_elem};
  assign transfer     = in_valid & in_ready;
  assign start_accept = (state == IDLE) & start;
  assign last_pair    = (idx == LAST);
  assign elem_idx     = idx;

`ifdef DOT_SEQ_OVF_EN
  logic [2*N:0] sum_ext;
  logic         carry;
  logic         ovf_flag;

  assign sum_ext = {1'b0, acc} + {1'b0, prod};
  assign sum     = sum_ext[2*N-1:0];
  assign carry   = sum_ext[2*N];
  assign ovf     = ovf_flag & out_valid;

  // Sticky carry-out flag, scoped to a single command.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_flag <= 1'b0;
    end else if (start_accept) begin
      ovf_flag <= 1'b0;
    end else if (transfer && carry) begin
      ovf_flag <= 1'b1;
    end
  end
`else
  assign sum = acc + prod;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = LOAD;
      end
      LOAD: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid && last_pair) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The result register is only loaded by the final pair so it holds steady through IDLE and LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      idx    <= '0;
      result <= '0;
    end else if (start_accept) begin
      acc <= '0;
      idx <= '0;
    end else if (transfer) begin
      acc <= sum;
      if (last_pair) begin
        idx    <= '0;
        result <= sum;
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dot_product_seq_ctrl.sv
// Directed self-checking bench for dot_product_seq_ctrl (N=8); checks ovf when DOT_SEQ_OVF_EN is defined.
module tb_dot_product_seq_ctrl;

  localparam int N = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a_elem;
  logic [N-1:0]  b_elem;
  logic [2:0]    elem_idx;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   result;
`ifdef DOT_SEQ_OVF_EN
  logic          ovf;
`endif

  int checks = 0;
  int errors = 0;

  dot_product_seq_ctrl #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_elem    (a_elem),
    .b_elem    (b_elem),
    .elem_idx  (elem_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
`ifdef DOT_SEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkIdleOutputs(input string tag, input logic [15:0] expResult);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_elem_idx"}, 32'(elem_idx), 32'd0);
    checkOutput({tag, "_result"}, 32'(result), 32'(expResult));
`ifdef DOT_SEQ_OVF_EN
    checkOutput({tag, "_ovf"}, 32'(ovf), 32'd0);
`endif
  endtask

  task automatic applyStimulus(input logic doStart, input logic doValid, input logic doOutReady);
    start     = doStart;
    in_valid  = doValid;
    out_ready = doOutReady;
    tick();
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  // Streams N pairs a_i = aBase + i*aStep, b_i = b; optional idle gaps and stray start pulses.
  task automatic loadPairs(input string tag, input int aBase, input int aStep, input int b,
                           input int gap, input logic startNoise);
    for (int i = 0; i < N; i++) begin
      a_elem   = 8'(aBase + i * aStep);
      b_elem   = 8'(b);
      in_valid = 1'b1;
      start    = startNoise;
      tick();
      in_valid = 1'b0;
      start    = 1'b0;
      for (int g = 0; g < gap; g++) begin
        start = startNoise;
        tick();
        start = 1'b0;
      end
      if (i < N - 1) begin
        checkOutput({tag, "_idx"}, 32'(elem_idx), 32'(i + 1));
        checkOutput({tag, "_no_valid_yet"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      end
    end
  endtask

  task automatic checkDone(input string tag, input logic [15:0] expResult, input logic expOvf);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_result"}, 32'(result), 32'(expResult));
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    checkOutput({tag, "_idx_wrap"}, 32'(elem_idx), 32'd0);
`ifdef DOT_SEQ_OVF_EN
    checkOutput({tag, "_ovf"}, 32'(ovf), 32'(expOvf));
`else
    if (expOvf) $display("[TB] %s expects carry-out (ovf port not built)", tag);
`endif
  endtask

  // Full command: start, N pairs, verify DONE, then handshake back to IDLE.
  task automatic runCommand(input string tag, input int aBase, input int aStep, input int b,
                            input int gap, input logic startNoise,
                            input logic [15:0] expResult, input logic expOvf);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    checkOutput({tag, "_idx_start"}, 32'(elem_idx), 32'd0);
    loadPairs(tag, aBase, aStep, b, gap, startNoise);
    checkDone(tag, expResult, expOvf);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkIdleOutputs({tag, "_post"}, expResult);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_elem = '0; b_elem = '0;
    tick();
    tick();
    checkIdleOutputs("reset", 16'd0);
    rst = 1'b0;
    tick();
    checkIdleOutputs("reset_hold", 16'd0);

    $display("[TB] basic 3*5 x8");
    runCommand("basic", 3, 0, 5, 0, 1'b0, 16'd120, 1'b0);

    $display("[TB] wrap 255*255 x8");
    runCommand("wrap", 255, 0, 255, 0, 1'b0, 16'd61448, 1'b1);
    runCommand("after_wrap", 1, 0, 1, 0, 1'b0, 16'd8, 1'b0);

    $display("[TB] input gaps");
    runCommand("gaps", 1, 1, 2, 3, 1'b0, 16'd72, 1'b0);

    $display("[TB] output backpressure");
    applyStimulus(1'b1, 1'b0, 1'b0);
    loadPairs("bp", 4, 0, 4, 0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      checkDone("bp_hold", 16'd128, 1'b0);
      applyStimulus(c[0], 1'b0, 1'b0);
    end
    checkDone("bp_hold_end", 16'd128, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkIdleOutputs("bp_handshake", 16'd128);
    tick();
    checkIdleOutputs("bp_stay_idle", 16'd128);

    $display("[TB] reset mid-LOAD");
    applyStimulus(1'b1, 1'b0, 1'b0);
    a_elem = 8'd7; b_elem = 8'd9;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("midrst_idx4", 32'(elem_idx), 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkIdleOutputs("midrst", 16'd0);
    runCommand("after_midrst", 1, 0, 1, 0, 1'b0, 16'd8, 1'b0);

    $display("[TB] command filtering");
    a_elem = 8'd50; b_elem = 8'd50;
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkIdleOutputs("filter_idle_valid", 16'd8);
    runCommand("filter", 2, 0, 3, 1, 1'b1, 16'd48, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
